// File: rtl/game_ctrl.sv
// ---------------------------------------------------------------------------
// game_ctrl -- memory game round controller.
//
// A round shows a four-digit BCD target for SHOW_CYCLES cycles. The player
// then keys in four digits within ENTRY_TIMEOUT cycles. A correct entry
// scores a point. A wrong or late entry costs a life. The game ends when
// no lives remain.
//
// Parameters
//   SHOW_CYCLES    cycles the target stays on the display   (1..65535)
//   ENTRY_TIMEOUT  cycles allowed for entering four digits  (1..65535)
//   MAX_LIVES      lives at the start of a game             (1..3)
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-low reset
//   start        start / restart request, honoured only in IDLE and OVER
//   rand_val     four BCD digits from the random generator
//   rand_load    one-cycle pulse: rand_val is captured at the end of it
//   digit_valid  qualifies digit for one cycle
//   digit        keypad digit; values above 9 are discarded
//   show         high while the target is displayed
//   disp_val     target while show=1, otherwise user_val
//   user_val     digits entered so far, most recent in the low nibble
//   score        rounds won, saturating at 255
//   lives        remaining lives
//   round_win    one-cycle pulse on a correct round
//   round_fail   one-cycle pulse on a wrong or timed-out round
//   game_over    high while in OVER
//
// Every output comes straight from a flop, so each registered output is
// loaded with the value that belongs to the state being entered.
// ---------------------------------------------------------------------------
module game_ctrl #(
  parameter int SHOW_CYCLES   = 8,
  parameter int ENTRY_TIMEOUT = 64,
  parameter int MAX_LIVES     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] rand_val,
  output logic        rand_load,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  output logic        show,
  output logic [15:0] disp_val,
  output logic [15:0] user_val,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        round_win,
  output logic        round_fail,
  output logic        game_over
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHOW   = 3'd2;
  localparam logic [2:0] ST_ENTRY  = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;
  localparam logic [2:0] ST_OVER   = 3'd6;

  // Terminal counts: a phase of N cycles ends when the counter reads N-1.
  localparam logic [15:0] SHOW_LAST  = 16'(SHOW_CYCLES - 1);
  localparam logic [15:0] ENTRY_LAST = 16'(ENTRY_TIMEOUT - 1);
  localparam logic [1:0]  LIVES_INIT = 2'(MAX_LIVES);

  logic [2:0]  state_q,      state_d;
  logic [15:0] cnt_q,        cnt_d;        // SHOW duration / ENTRY timeout
  logic [2:0]  dcnt_q,       dcnt_d;       // accepted digits this round
  logic [15:0] target_q,     target_d;
  logic [15:0] user_val_q,   user_val_d;
  logic [15:0] disp_val_q,   disp_val_d;
  logic [7:0]  score_q,      score_d;
  logic [1:0]  lives_q,      lives_d;
  logic        rand_load_q,  rand_load_d;
  logic        show_q,       show_d;
  logic        round_win_q,  round_win_d;
  logic        round_fail_q, round_fail_d;
  logic        game_over_q,  game_over_d;

  logic digit_ok;

  assign digit_ok = digit_valid && (digit <= 4'd9);

  always_comb begin
    // NOTE: every signal gets a default first, so a path that does not
    // assign it holds its value instead of inferring a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    dcnt_d       = dcnt_q;
    target_d     = target_q;
    user_val_d   = user_val_q;
    score_d      = score_q;
    lives_d      = lives_q;
    rand_load_d  = 1'b0;
    show_d       = 1'b0;
    round_win_d  = 1'b0;
    round_fail_d = 1'b0;
    game_over_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          rand_load_d = 1'b1;
          lives_d     = LIVES_INIT;
          score_d     = 8'd0;
        end
      end

      ST_LOAD: begin
        target_d   = rand_val;
        user_val_d = 16'd0;
        dcnt_d     = 3'd0;
        cnt_d      = 16'd0;
        show_d     = 1'b1;
        state_d    = ST_SHOW;
      end

      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_ENTRY;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          show_d = 1'b1;
        end
      end

      ST_ENTRY: begin
        if (digit_ok) begin
          user_val_d = {user_val_q[11:0], digit};
          dcnt_d     = dcnt_q + 3'd1;
        end
        // The fourth digit takes priority over a timeout on the same cycle.
        if (digit_ok && (dcnt_q == 3'd3)) begin
          state_d = ST_CHECK;
        end else if (cnt_q == ENTRY_LAST) begin
          state_d      = ST_RESULT;
          round_fail_d = 1'b1;
          lives_d      = lives_q - 2'd1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_CHECK: begin
        state_d = ST_RESULT;
        if (user_val_q == target_q) begin
          round_win_d = 1'b1;
          score_d     = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        end else begin
          round_fail_d = 1'b1;
          lives_d      = lives_q - 2'd1;
        end
      end

      ST_RESULT: begin
        // lives_q already holds the post-round count.
        if (lives_q == 2'd0) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
        end else begin
          state_d     = ST_LOAD;
          rand_load_d = 1'b1;
        end
      end

      ST_OVER: begin
        if (start) begin
          state_d     = ST_LOAD;
          rand_load_d = 1'b1;
          lives_d     = LIVES_INIT;
          score_d     = 8'd0;
        end else begin
          game_over_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The display follows the next-cycle values so it stays registered.
    disp_val_d = show_d ? target_d : user_val_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge (synchronous), and all state
    // updates use non-blocking assignments so every flop sees pre-edge values.
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      dcnt_q       <= 3'd0;
      target_q     <= 16'd0;
      user_val_q   <= 16'd0;
      disp_val_q   <= 16'd0;
      score_q      <= 8'd0;
      lives_q      <= LIVES_INIT;
      rand_load_q  <= 1'b0;
      show_q       <= 1'b0;
      round_win_q  <= 1'b0;
      round_fail_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dcnt_q       <= dcnt_d;
      target_q     <= target_d;
      user_val_q   <= user_val_d;
      disp_val_q   <= disp_val_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      rand_load_q  <= rand_load_d;
      show_q       <= show_d;
      round_win_q  <= round_win_d;
      round_fail_q <= round_fail_d;
      game_over_q  <= game_over_d;
    end
  end

  assign rand_load  = rand_load_q;
  assign show       = show_q;
  assign disp_val   = disp_val_q;
  assign user_val   = user_val_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign round_win  = round_win_q;
  assign round_fail = round_fail_q;
  assign game_over  = game_over_q;

endmodule
